// File: rtl/adder_multicycle_if.sv
// Operand/result stream bundle for adder_multicycle: val/rdy handshake on both sides.
// master drives operands and result-ready; slave is the adder.
interface adder_multicycle_if #(
    parameter int unsigned p_nbits = 32
);
    logic               istream_val;
    logic               istream_rdy;
    logic [p_nbits-1:0] istream_a;
    logic [p_nbits-1:0] istream_b;
    logic               istream_cin;
    logic               ostream_val;
    logic               ostream_rdy;
    logic [p_nbits-1:0] ostream_sum;
    logic               ostream_cout;

    modport master (
        output istream_val, istream_a, istream_b, istream_cin, ostream_rdy,
        input  istream_rdy, ostream_val, ostream_sum, ostream_cout
    );

    modport slave (
        input  istream_val, istream_a, istream_b, istream_cin, ostream_rdy,
        output istream_rdy, ostream_val, ostream_sum, ostream_cout
    );
endinterface

// File: rtl/adder_multicycle.sv
// Iterative adder: a + b + cin computed p_nbits_per_cycle bits per cycle through
// one chunk adder and a registered carry, with val/rdy streams in and out.
module adder_multicycle #(
    parameter int unsigned p_nbits           = 32,
    parameter int unsigned p_nbits_per_cycle = 4
) (
    input logic               clk,
    input logic               reset,
    adder_multicycle_if.slave bus
);
    localparam int unsigned W  = (p_nbits_per_cycle == 0) ? 1 : p_nbits_per_cycle;
    localparam int unsigned N  = (p_nbits / W == 0) ? 1 : p_nbits / W;
    localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    if (p_nbits < 1 || p_nbits_per_cycle < 1 || (p_nbits % W) != 0) begin : g_bad_cfg
        $error("adder_multicycle: p_nbits_per_cycle must be >= 1 and divide p_nbits");
    end

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [p_nbits-1:0] a_q, a_d;
    logic [p_nbits-1:0] b_q, b_d;
    logic [p_nbits-1:0] sum_q, sum_d;
    logic               carry_q, carry_d;
    logic [W:0]         chunk;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        chunk   = {1'b0, a_q[W-1:0]} + {1'b0, b_q[W-1:0]} + {{W{1'b0}}, carry_q};

        unique case (state_q)
            IDLE: begin
                if (bus.istream_val) begin
                    a_d     = bus.istream_a;
                    b_d     = bus.istream_b;
                    carry_d = bus.istream_cin;
                    cnt_d   = '0;
                    state_d = CALC;
                end
            end
            CALC: begin
                // Each chunk enters at the MSB end so the first chunk ends up at bit 0.
                sum_d   = (sum_q >> W) | (p_nbits'(chunk[W-1:0]) << (p_nbits - W));
                carry_d = chunk[W];
                a_d     = a_q >> W;
                b_d     = b_q >> W;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.ostream_rdy) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.istream_rdy  = (state_q == IDLE) && !reset;
    assign bus.ostream_val  = (state_q == DONE);
    assign bus.ostream_sum  = sum_q;
    assign bus.ostream_cout = carry_q;
endmodule
